// File: rtl/net_pkg.sv
// Shared constants and state type for the network line packer.
package net_pkg;
  localparam int NET_LINE_W = 1048;
  localparam int NET_BEAT_W = 32;
  localparam int NET_BEATS_PER_LINE = 33;
  localparam int NET_RAM_DEPTH = 1024;

  typedef enum logic [2:0] {
    NP_IDLE,
    NP_FILL,
    NP_WRITE,
    NP_DRAIN,
    NP_DONE
  } net_packer_state_t;
endpackage

// File: rtl/net_beat_slot_writer.sv
// Merges one stream beat into its slot of the line buffer.
// Optional byte reversal under NET_PACKER_BYTE_SWAP_EN.
module net_beat_slot_writer
  import net_pkg::*;
(
  input  logic [NET_LINE_W-1:0] line_i,
  input  logic [NET_BEAT_W-1:0] beat_i,
  input  logic [5:0]            slot_i,
  output logic [NET_LINE_W-1:0] line_o
);
  localparam int FULL = NET_BEATS_PER_LINE - 1;
  localparam int TAIL_W = NET_LINE_W - FULL * NET_BEAT_W;

  logic [NET_BEAT_W-1:0] beat;

`ifdef NET_PACKER_BYTE_SWAP_EN
  assign beat = {beat_i[7:0], beat_i[15:8],
                 beat_i[23:16], beat_i[31:24]};
`else
  assign beat = beat_i;
`endif

  // The final slot is narrower; only its low bytes land in the line.
  always_comb begin
    line_o = line_i;
    for (int k = 0; k < FULL; k++) begin
      if (slot_i == 6'(k))
        line_o[k*NET_BEAT_W +: NET_BEAT_W] = beat;
    end
    if (slot_i == 6'(FULL))
      line_o[NET_LINE_W-1 -: TAIL_W] = beat[TAIL_W-1:0];
  end
endmodule

// File: rtl/net_line_packer.sv
// Packs a 32-bit beat stream into 1048-bit RAM lines.
// Optional feature macro: NET_PACKER_BYTE_SWAP_EN.
module net_line_packer
  import net_pkg::*;
#(
  parameter int MAX_LINES = NET_RAM_DEPTH,
  parameter int CNT_W     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [NET_LINE_W-1:0] mem_d,
  output logic [31:0]           mem_addr,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      lines_written,
  output logic                  overflow
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LINES);
  localparam logic [5:0] LAST_SLOT = 6'(NET_BEATS_PER_LINE - 1);

  net_packer_state_t state_q, state_d;
  logic [NET_LINE_W-1:0] buf_q, buf_d, merged;
  logic [5:0]            beat_q, beat_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [31:0]           base_q, base_d;
  logic [31:0]           addr_q, addr_d;
  logic pend_q, pend_d;
  logic ovf_q, ovf_d;
  logic we_q, we_d;
  logic rdy_q, rdy_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic acc;

  assign acc = rdy_q & in_valid;

  net_beat_slot_writer u_slot (
    .line_i (buf_q),
    .beat_i (in_data),
    .slot_i (beat_q),
    .line_o (merged)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    base_d  = base_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    unique case (state_q)
      NP_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          buf_d   = '0;
          beat_d  = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = NP_FILL;
        end
      end
      NP_FILL: begin
        if (acc) begin
          buf_d  = merged;
          beat_d = beat_q + 6'd1;
          if (beat_q == LAST_SLOT || in_last) begin
            state_d = NP_WRITE;
            pend_d  = in_last;
            // Write strobe and address are staged so they are registered.
            if (idx_q < MAX_C) begin
              we_d   = 1'b1;
              addr_d = base_q + 32'(idx_q);
            end
          end
        end
      end
      NP_WRITE: begin
        if (we_q) idx_d = idx_q + 1'b1;
        else      ovf_d = 1'b1;
        if (pend_q) begin
          state_d = NP_DONE;
        end else if (!we_q) begin
          state_d = NP_DRAIN;
        end else begin
          buf_d   = '0;
          beat_d  = '0;
          state_d = NP_FILL;
        end
      end
      NP_DRAIN: begin
        if (acc && in_last) state_d = NP_DONE;
      end
      NP_DONE: state_d = NP_IDLE;
      default: state_d = NP_IDLE;
    endcase
    rdy_d  = (state_d == NP_FILL) || (state_d == NP_DRAIN);
    busy_d = (state_d != NP_IDLE);
    done_d = (state_d == NP_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NP_IDLE;
      buf_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready      = rdy_q;
  assign mem_d         = buf_q;
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_written = idx_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_net_line_packer.sv
// Scoreboard bench for net_line_packer against a packet-level model.
module tb_net_line_packer;
  localparam int MAXL = 3;
  localparam int LW = 1048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [LW-1:0] mem_d;
  logic [31:0] mem_addr;
  logic mem_we, busy, done, overflow;
  logic [10:0] lines_written;

  net_line_packer #(.MAX_LINES(MAXL), .CNT_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mem_d(mem_d), .mem_addr(mem_addr),
    .mem_we(mem_we), .busy(busy), .done(done),
    .lines_written(lines_written), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic [LW-1:0] data;
  } wr_t;
  typedef struct {
    int lines;
    bit ovf;
  } pk_t;

  wr_t wq[$];
  pk_t pq[$];
  logic [31:0] pk[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_we = -100;
  int n_done = 0;
  int exp_done = 0;

  function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef NET_PACKER_BYTE_SWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // Line l holds beats 33l..33l+32; only the first MAXL lines are stored.
  function automatic void model(input logic [31:0] b);
    int n = pk.size();
    int nl = (n + 32) / 33;
    wr_t w;
    pk_t p;
    for (int l = 0; l < nl && l < MAXL; l++) begin
      w.addr = b + 32'(l);
      w.data = '0;
      for (int j = 0; j < 33; j++) begin
        int i = l * 33 + j;
        if (i < n) begin
          logic [31:0] v = sw(pk[i]);
          if (j < 32) w.data[j*32 +: 32] = v;
          else        w.data[1024 +: 24] = v[23:0];
        end
      end
      wq.push_back(w);
    end
    p.lines = (nl < MAXL) ? nl : MAXL;
    p.ovf = nl > MAXL;
    pq.push_back(p);
    exp_done++;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_we) begin
        wr_t e;
        last_we = cyc;
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ready_in_write got=%b exp=0", in_ready);
        end
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write addr=%h exp=none", mem_addr);
        end else begin
          e = wq.pop_front();
          if (mem_addr !== e.addr) begin
            n_err++;
            $display("FAIL write_addr got=%h exp=%h", mem_addr, e.addr);
          end else if (mem_d !== e.data) begin
            logic [1055:0] ga, ea;
            int fw = 0;
            ga = {8'b0, mem_d};
            ea = {8'b0, e.data};
            for (int k = 32; k >= 0; k--)
              if (ga[k*32 +: 32] !== ea[k*32 +: 32]) fw = k;
            n_err++;
            $display("FAIL write_data addr=%h word%0d got=%h exp=%h",
                     mem_addr, fw, ga[fw*32 +: 32], ea[fw*32 +: 32]);
          end
        end
      end
      if (done) begin
        pk_t p;
        n_done++;
        n_cmp++;
        if (pq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          p = pq.pop_front();
          if (lines_written !== 11'(p.lines) || overflow !== p.ovf) begin
            n_err++;
            $display("FAIL done_status lines=%0d ovf=%b exp lines=%0d ovf=%b",
                     lines_written, overflow, p.lines, p.ovf);
          end
          if (!p.ovf) begin
            n_cmp++;
            if (cyc - last_we != 1) begin
              n_err++;
              $display("FAIL done_latency got=%0d exp=1", cyc - last_we);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
  endtask

  task automatic run_pkt(input logic [31:0] b, input int gap,
                         input int abort_at);
    int n = pk.size();
    wait_idle();
    if (abort_at < 0) model(b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = $urandom;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit rdy;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_we", 64'(mem_we), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_lines", 64'(lines_written), 0);
        in_valid = 1'b0;
        in_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      while ($urandom_range(0, 99) < gap) begin
        in_valid = 1'b0;
        start = 1'($urandom_range(0, 1));
        base_addr = $urandom;
        @(posedge clk); #1;
      end
      start = 1'b0;
      in_valid = 1'b1;
      in_data = pk[i];
      in_last = (i == n - 1);
      do begin
        rdy = in_ready;
        @(posedge clk); #1;
        t++;
      end while (!rdy && t < 500);
      if (!rdy) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_timeout beat=%0d got=not_ready exp=ready", i);
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_d_zero", 64'(mem_d == '0), 1);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_lines", 64'(lines_written), 0);
    chk("rst_ovf", 64'(overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pk.delete();
    for (int k = 0; k < 33; k++) pk.push_back(32'h1000 + 32'(k));
    run_pkt(32'h10, 0, -1);

    pk.delete();
    for (int k = 1; k <= 3; k++) pk.push_back(32'hAAAA0000 + 32'(k));
    run_pkt($urandom, 0, -1);

    pk.delete();
    for (int k = 0; k < 70; k++) pk.push_back($urandom);
    run_pkt(32'h400, 40, -1);

    pk.delete();
    for (int k = 0; k < 140; k++) pk.push_back($urandom);
    run_pkt(32'h800, 10, -1);

    pk.delete();
    for (int k = 0; k < 20; k++) pk.push_back($urandom);
    run_pkt(32'h300, 0, 10);

    pk.delete();
    for (int k = 0; k < 5; k++) pk.push_back($urandom);
    run_pkt(32'h200, 20, -1);

    pk.delete();
    pk.push_back(32'h11223344);
    run_pkt(32'h0, 0, -1);

    pk.delete();
    for (int k = 0; k < 66; k++) pk.push_back($urandom);
    run_pkt(32'hFFFF_FFFF, 15, -1);

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 110);
      pk.delete();
      for (int k = 0; k < n; k++) pk.push_back($urandom);
      run_pkt($urandom, $urandom_range(0, 50), -1);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("writes_left", 64'(wq.size()), 0);
    chk("pkts_left", 64'(pq.size()), 0);
    chk("done_count", 64'(n_done), 64'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
